// File: rtl/axi_burst_pkg.sv
// Shared AXI4 encodings and the burst writer state type.
package axi_burst_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_ID_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } writer_state_t;

endpackage

// File: rtl/s_axi_bus.sv
// AXI4-Full bus bundle shared by the burst writer and the memory slave.
interface s_axi_bus
    import axi_burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [AXI_ID_W-1:0] awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [AXI_ID_W-1:0] arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/stream_to_axi_burst_writer.sv
// Splits a streamed job into INCR bursts and writes it over AXI4 AW/W/B.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high.
module stream_to_axi_burst_writer
    import axi_burst_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int BURST_LEN          = 16,
    parameter int AXI_ID             = 0,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_base_address,
    input  logic [CNT_WIDTH-1:0]          i_num_words,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    s_axi_bus.master                      m_axi
);
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    writer_state_t                 state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]          remaining_q;
    logic [7:0]                    awlen_q;
    logic [7:0]                    beat_q;
    logic                          awvalid_q;
    logic                          bready_q;

    function automatic logic [7:0] burst_awlen(input logic [CNT_WIDTH-1:0] rem);
        if (rem >= CNT_WIDTH'(BURST_LEN))
            return 8'(BURST_LEN - 1);
        return 8'(rem - 1'b1);
    endfunction

    logic [8:0]                    beats;
    logic [CNT_WIDTH-1:0]          remaining_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_next;
    logic                          in_data;
    logic                          last_beat;
    logic                          w_hs;

    assign beats          = {1'b0, awlen_q} + 9'd1;
    assign remaining_next = remaining_q - CNT_WIDTH'(beats);
    // Wraps modulo the address width; no 4 KB boundary split.
    assign addr_next      = addr_q + (C_M_AXI_ADDR_WIDTH'(beats) << SIZE);
    assign in_data        = (state == ST_DATA);
    assign last_beat      = in_data && (beat_q == awlen_q);
    assign w_hs           = m_axi.wvalid && m_axi.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q      <= i_base_address;
                        remaining_q <= i_num_words;
                        awlen_q     <= burst_awlen(i_num_words);
                        o_error     <= 1'b0;
                        o_busy      <= 1'b1;
                        if (i_num_words == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_ADDR;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_q    <= 1'b0;
                        remaining_q <= remaining_next;
                        addr_q      <= addr_next;
                        if (m_axi.bresp != RESP_OKAY)
                            o_error <= 1'b1;
                        if (remaining_next == '0) begin
                            state <= ST_DONE;
                        end else begin
                            awlen_q   <= burst_awlen(remaining_next);
                            awvalid_q <= 1'b1;
                            state     <= ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axi.awid    = AXI_ID_W'(AXI_ID);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = 3'(SIZE);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awvalid = awvalid_q;

    // W is a straight pass-through of the stream, gated to the DATA state.
    assign m_axi.wdata   = i_data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = last_beat;
    assign m_axi.wvalid  = in_data && i_valid;
    assign o_ready       = in_data && m_axi.wready;

    assign m_axi.bready  = bready_q;

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = '0;
    assign m_axi.arlen   = '0;
    assign m_axi.arsize  = '0;
    assign m_axi.arburst = '0;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;

    logic unused_read_side;
    assign unused_read_side = ^{m_axi.bid, m_axi.arready, m_axi.rid, m_axi.rdata,
                                m_axi.rresp, m_axi.rlast, m_axi.rvalid};

endmodule

// File: tb/tb_stream_to_axi_burst_writer.sv
// Directed bench for stream_to_axi_burst_writer with a small AXI memory slave.
module tb_stream_to_axi_burst_writer;
    import axi_burst_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_address = '0;
    logic [CW-1:0] i_num_words = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready, o_busy, o_done, o_error;

    s_axi_bus #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    stream_to_axi_burst_writer #(
        .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW),
        .BURST_LEN(16), .AXI_ID(0), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_base_address(i_base_address), .i_num_words(i_num_words),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .m_axi(bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [15:0]   exp_aw_q[$];   // {awaddr, awlen}
    logic [DW-1:0] src[$];
    logic [1:0]    bresp_plan[$];
    logic [DW-1:0] mem [0:63];
    int            consumed = 0;
    bit            toggle_mode = 1'b0;
    bit            phase = 1'b0;
    int            done_cnt = 0;
    int            b_cnt = 0;
    bit            aw_seen = 1'b0;
    int            w_beat = 0;
    logic [7:0]    cur_len = '0;

    // ---------------- AXI memory slave ----------------
    logic       aw_got;
    logic [5:0] wr_ptr;

    function automatic logic [1:0] next_resp();
        if (bresp_plan.size() > 0)
            return bresp_plan.pop_front();
        return 2'b00;
    endfunction

    assign bus.bid     = '0;
    assign bus.arready = 1'b0;
    assign bus.rid     = '0;
    assign bus.rdata   = '0;
    assign bus.rresp   = '0;
    assign bus.rlast   = 1'b0;
    assign bus.rvalid  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            aw_got      <= 1'b0;
            wr_ptr      <= '0;
        end else begin
            bus.awready <= bus.awvalid && !bus.awready;
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1'b1;
                wr_ptr <= bus.awaddr[7:2];
            end
            bus.wready <= aw_got && !(bus.wvalid && bus.wready && bus.wlast);
            if (bus.wvalid && bus.wready) begin
                mem[wr_ptr] <= bus.wdata;
                wr_ptr      <= wr_ptr + 6'd1;
                if (bus.wlast) begin
                    aw_got     <= 1'b0;
                    bus.bvalid <= 1'b1;
                    bus.bresp  <= next_resp();
                end
            end
            if (bus.bvalid && bus.bready)
                bus.bvalid <= 1'b0;
        end
    end

    // ---------------- stream driver ----------------
    always @(negedge clk) begin
        phase = !phase;
        if (consumed < src.size() && (!toggle_mode || phase)) begin
            i_valid = 1'b1;
            i_data  = src[consumed];
        end else begin
            i_valid = 1'b0;
            i_data  = '0;
        end
    end

    // ---------------- bus monitor ----------------
    always @(posedge clk) begin
        logic [15:0]   e_aw;
        logic [DW-1:0] e_w;
        if (rst) begin
            w_beat = 0;
        end else begin
            if (i_valid && o_ready) consumed++;
            if (bus.awvalid) aw_seen = 1'b1;
            if (o_done) done_cnt++;
            if (bus.bvalid && bus.bready) b_cnt++;
            if (bus.awvalid && bus.awready) begin
                e_aw = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 'x;
                check_eq("aw_addr_len", {bus.awaddr, bus.awlen}, e_aw);
                check_eq("aw_attrs", {bus.awid, bus.awsize, bus.awburst, bus.awlock},
                         {4'd0, 3'd2, 2'b01, 1'b0});
                cur_len = e_aw[7:0];
                w_beat  = 0;
            end
            if (bus.wvalid && bus.wready) begin
                e_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check_eq("wdata", bus.wdata, e_w);
                check_eq("wlast", bus.wlast, (w_beat == int'(cur_len)));
                check_eq("wstrb", bus.wstrb, 4'hF);
                w_beat++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic prep_stream(input logic [DW-1:0] first, input int n);
        src.delete();
        consumed = 0;
        for (int i = 0; i < n; i++) begin
            src.push_back(first + DW'(i));
            exp_q.push_back(first + DW'(i));
        end
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] num);
        @(negedge clk);
        i_base_address = base;
        i_num_words    = num;
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        check_eq({tag, "_busy_at_done"}, o_busy, 1'b0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int d0;
        int b0;
        bit reached;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {bus.awvalid, bus.wvalid, bus.bready, o_ready, o_busy, o_done, o_error}, 7'd0);
        check_eq("reset_state", dut.state, ST_IDLE);
        rst = 1'b0;

        // 1: single short burst at 0x10
        prep_stream(32'hA000_0000, 4);
        exp_aw_q.push_back({8'h10, 8'd3});
        start_job(8'h10, 16'd4);
        check_eq("t1_awvalid_after_1", {o_busy, bus.awvalid, bus.awaddr, bus.awlen},
                 {1'b1, 1'b1, 8'h10, 8'h03});
        wait_done("t1");
        check_eq("t1_error", o_error, 1'b0);
        @(negedge clk);
        check_eq("t1_done_one_cycle", o_done, 1'b0);
        check_eq("t1_mem4", mem[4], 32'hA000_0000);
        check_eq("t1_mem7", mem[7], 32'hA000_0003);
        check_eq("t1_mem8_untouched", mem[8], 32'h0);
        check_eq("t1_leftover", exp_aw_q.size() + exp_q.size(), 0);

        // 2: 20 words split 16+4, stray start while busy
        prep_stream(32'hB000_0000, 20);
        exp_aw_q.push_back({8'h00, 8'd15});
        exp_aw_q.push_back({8'h40, 8'd3});
        d0 = done_cnt;
        b0 = b_cnt;
        start_job(8'h00, 16'd20);
        repeat (5) @(negedge clk);
        i_base_address = 8'h80;
        i_num_words    = 16'd1;
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("t2");
        check_eq("t2_b_count_at_done", b_cnt - b0, 2);
        repeat (4) @(negedge clk);
        check_eq("t2_single_done", done_cnt - d0, 1);
        check_eq("t2_idle_after", o_busy, 1'b0);
        check_eq("t2_mem0", mem[0], 32'hB000_0000);
        check_eq("t2_mem16", mem[16], 32'hB000_0010);
        check_eq("t2_mem19", mem[19], 32'hB000_0013);
        check_eq("t2_leftover", exp_aw_q.size() + exp_q.size(), 0);

        // 3: zero-length job
        aw_seen = 1'b0;
        start_job(8'h30, 16'd0);
        check_eq("t3_cycle1", {o_busy, o_done}, 2'b10);
        @(negedge clk);
        check_eq("t3_cycle2", {o_busy, o_done}, 2'b01);
        @(negedge clk);
        check_eq("t3_cycle3", {o_busy, o_done}, 2'b00);
        check_eq("t3_no_awvalid", aw_seen, 1'b0);

        // 4: stream valid every other cycle
        toggle_mode = 1'b1;
        prep_stream(32'hC000_0000, 6);
        exp_aw_q.push_back({8'h80, 8'd5});
        start_job(8'h80, 16'd6);
        wait_done("t4");
        toggle_mode = 1'b0;
        check_eq("t4_mem32", mem[32], 32'hC000_0000);
        check_eq("t4_mem37", mem[37], 32'hC000_0005);
        check_eq("t4_leftover", exp_aw_q.size() + exp_q.size(), 0);

        // 5: SLVERR on first of two bursts
        bresp_plan.push_back(2'b10);
        bresp_plan.push_back(2'b00);
        prep_stream(32'hD000_0000, 20);
        exp_aw_q.push_back({8'h20, 8'd15});
        exp_aw_q.push_back({8'h60, 8'd3});
        start_job(8'h20, 16'd20);
        wait_done("t5");
        check_eq("t5_error_at_done", o_error, 1'b1);
        @(negedge clk);
        check_eq("t5_error_sticky", o_error, 1'b1);
        prep_stream(32'hE000_0000, 1);
        exp_aw_q.push_back({8'h50, 8'd0});
        start_job(8'h50, 16'd1);
        check_eq("t5_error_cleared", o_error, 1'b0);
        wait_done("t5b");
        check_eq("t5b_error", o_error, 1'b0);
        check_eq("t5_mem20", mem[20], 32'hE000_0000);

        // 6: reset during DATA, then a job whose second burst wraps to 0x00
        prep_stream(32'hF000_0000, 16);
        exp_aw_q.push_back({8'h00, 8'd15});
        start_job(8'h00, 16'd16);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (consumed >= 3) reached = 1'b1;
        end
        check_eq("t6_reached_data", reached, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_outputs", {bus.awvalid, bus.wvalid, o_busy, o_done}, 4'd0);
        check_eq("t6_rst_state", dut.state, ST_IDLE);
        rst = 1'b0;
        src.delete();
        consumed = 0;
        exp_q.delete();
        exp_aw_q.delete();
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check_eq("t6_no_done_after_abort", done_cnt - d0, 0);
        check_eq("t6_idle_after_abort", o_busy, 1'b0);

        prep_stream(32'h5A00_0000, 20);
        exp_aw_q.push_back({8'hC0, 8'd15});
        exp_aw_q.push_back({8'h00, 8'd3});
        start_job(8'hC0, 16'd20);
        wait_done("t6");
        check_eq("t6_error", o_error, 1'b0);
        check_eq("t6_mem48", mem[48], 32'h5A00_0000);
        check_eq("t6_mem63", mem[63], 32'h5A00_000F);
        check_eq("t6_mem0_wrapped", mem[0], 32'h5A00_0010);
        check_eq("t6_mem3_wrapped", mem[3], 32'h5A00_0013);
        check_eq("t6_leftover", exp_aw_q.size() + exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
